xillybus_apfifo_bridge: RTL
===========================

XILLYBUS_APFIFO_BRIDGE -- requirements
Module: xillybus_apfifo_bridge

Interface
REQ-001 SHALL have parameter DATA_W, default 128, word width in bits.
REQ-002 SHALL have parameter DEPTH_LOG2, default 4, log2 of FIFO depth per direction per channel (depth D = 2^DEPTH_LOG2, DEPTH_LOG2 >= 1).
REQ-003 SHALL have parameter NCH, default 2, number of independent channels.
REQ-004 SHALL use one clock and a synchronous, active-high reset.
REQ-005 SHALL have ports:
- bus_clk  input  1  sole clock; all logic on rising edge
- rst  input  1  synchronous active-high reset
- user_w_wren  input  NCH  host-to-IP write strobe per channel
- user_w_data  input  NCH*DATA_W  host-to-IP data; channel c at [c*DATA_W +: DATA_W]
- user_w_full  output  NCH  host-to-IP FIFO full
- user_w_open  input  NCH  host write file open
- in_r_dout  output  NCH*DATA_W  ap_fifo data to IP
- in_r_empty_n  output  NCH  in_r_dout valid
- in_r_read  input  NCH  IP consumes in_r_dout
- out_r_din  input  NCH*DATA_W  ap_fifo data from IP
- out_r_write  input  NCH  IP write strobe
- out_r_full  output  NCH  IP-to-host FIFO full
- user_r_rden  input  NCH  host read strobe
- user_r_data  output  NCH*DATA_W  IP-to-host data
- user_r_empty  output  NCH  IP-to-host FIFO empty
- user_r_eof  output  NCH  end-of-file to host
- user_r_open  input  NCH  host read file open
- ip_rst_n  output  1  registered active-low reset to IP

Function
REQ-006 Each channel SHALL contain two synchronous FIFOs of depth D: H2I (host-to-IP) and I2H (IP-to-host); channels fully independent.
REQ-007 Pointers SHALL wrap modulo D; occupancy counter DEPTH_LOG2+1 bits wide, range 0..D.
REQ-008 full = (count == D), empty = (count == 0), both decoded from registered count; write while full SHALL be dropped with no state change; read while empty SHALL be ignored.
REQ-009 Simultaneous accepted read and write SHALL leave count unchanged; at full, write blocked even if read occurs same cycle.
REQ-010 H2I output SHALL be a first-word-fall-through register: loads next word when in_r_empty_n=0 or in_r_read=1, and H2I non-empty.
REQ-011 Word written at edge k into empty H2I with empty output register SHALL appear on in_r_dout with in_r_empty_n=1 after edge k+1.
REQ-012 in_r_read with in_r_empty_n=0 SHALL be ignored; in_r_read with no further word SHALL clear in_r_empty_n next edge.
REQ-013 I2H read: user_r_data SHALL update at the edge following an accepted user_r_rden (one-cycle read latency) and hold otherwise.
REQ-014 user_w_open[c]=0 SHALL flush H2I[c] and clear in_r_empty_n[c] synchronously, every cycle it is low.
REQ-015 user_w_open[c]=0 and user_r_open[c]=0 together SHALL flush I2H[c].
REQ-016 ip_rst_n SHALL be registered; 0 when rst=1 or all channels have both files closed, else 1.

Reset
REQ-017 rst=1 SHALL clear all pointers and counts; user_w_full=0, out_r_full=0, user_r_empty=all ones, in_r_empty_n=0, in_r_dout=0, user_r_data=0, user_r_eof=0, ip_rst_n=0 after the edge.
REQ-018 Reset mid-transfer SHALL discard all buffered data; strobes during rst ignored.

Configuration
REQ-019 Macro XILLY_APFIFO_EOF_EN SHALL gate EOF generation.
REQ-020 With macro: per-channel seen_open flag set when user_w_open[c]=1, cleared by rst or REQ-015 flush; user_r_eof[c] registered, =1 when seen_open[c]=1, user_w_open[c]=0, I2H[c] empty.
REQ-021 Without macro: user_r_eof tied 0, no seen_open logic.

Verification
REQ-022 Open ch0, write 0x11..0x14 at consecutive edges, in_r_read=0 -> in_r_empty_n[0]=1 one edge after first write, in_r_dout=0x11 held; read 4 cycles -> 0x11..0x14 then in_r_empty_n=0.
REQ-023 DEPTH_LOG2=2: write 6 words without reads -> 4 stored plus output register holds 1; user_w_full=1; sixth dropped; drain yields exactly 5 words in order.
REQ-024 out_r_write 0xA5 on ch1 only; user_r_rden[1] -> user_r_data ch1=0xA5 next edge, ch0 outputs unchanged, user_r_empty=2'b11 after.
REQ-025 Close user_w_open[0] with 3 words buffered -> in_r_empty_n[0]=0 next edge; reopen -> FIFO empty; ip_rst_n stays 1 while user_r_open[0]=1.
REQ-026 EOF_EN: open then close ch0 write file with 2 words in I2H -> user_r_eof[0]=0 until second read, then 1; rst mid-stream -> all outputs per REQ-017.

Source files
------------

// File: rtl/xillybus_apfifo_bridge_if.sv
// Signal bundle between the Xillybus host streams and the HLS ap_fifo ports
// of xillybus_apfifo_bridge; the bridge uses the slave modport.
interface xillybus_apfifo_bridge_if #(
  parameter int unsigned DATA_W = 128,
  parameter int unsigned NCH    = 2
);
  logic [NCH-1:0]        user_w_wren;
  logic [NCH*DATA_W-1:0] user_w_data;
  logic [NCH-1:0]        user_w_full;
  logic [NCH-1:0]        user_w_open;
  logic [NCH*DATA_W-1:0] in_r_dout;
  logic [NCH-1:0]        in_r_empty_n;
  logic [NCH-1:0]        in_r_read;
  logic [NCH*DATA_W-1:0] out_r_din;
  logic [NCH-1:0]        out_r_write;
  logic [NCH-1:0]        out_r_full;
  logic [NCH-1:0]        user_r_rden;
  logic [NCH*DATA_W-1:0] user_r_data;
  logic [NCH-1:0]        user_r_empty;
  logic [NCH-1:0]        user_r_eof;
  logic [NCH-1:0]        user_r_open;
  logic                  ip_rst_n;

  modport slave (
    input  user_w_wren, user_w_data, user_w_open, in_r_read,
           out_r_din, out_r_write, user_r_rden, user_r_open,
    output user_w_full, in_r_dout, in_r_empty_n, out_r_full,
           user_r_data, user_r_empty, user_r_eof, ip_rst_n
  );

  modport master (
    output user_w_wren, user_w_data, user_w_open, in_r_read,
           out_r_din, out_r_write, user_r_rden, user_r_open,
    input  user_w_full, in_r_dout, in_r_empty_n, out_r_full,
           user_r_data, user_r_empty, user_r_eof, ip_rst_n
  );
endinterface

// File: rtl/xillybus_apfifo_bridge.sv
// Per-channel FIFO pair bridging Xillybus host streams to HLS ap_fifo ports.
// Define XILLY_APFIFO_EOF_EN to generate user_r_eof after the host write file closes.
module xillybus_apfifo_bridge #(
  parameter int unsigned DATA_W     = 128,
  parameter int unsigned DEPTH_LOG2 = 4,
  parameter int unsigned NCH        = 2
) (
  input  logic                     bus_clk,
  input  logic                     rst,
  xillybus_apfifo_bridge_if.slave  bus
);
  localparam int unsigned D  = 1 << DEPTH_LOG2;
  localparam int unsigned CW = DEPTH_LOG2 + 1;

  logic ip_rst_n_q;

  for (genvar c = 0; c < NCH; c++) begin : g_ch
    // Host-to-IP FIFO followed by a first-word-fall-through output register
    logic [DATA_W-1:0]     h2i_mem [D];
    logic [DEPTH_LOG2-1:0] h2i_wp, h2i_rp;
    logic [CW-1:0]         h2i_cnt;
    logic                  h2i_full, h2i_empty, h2i_wr, h2i_rd, h2i_flush;
    logic [DATA_W-1:0]     dout_q;
    logic                  vld_q;

    assign h2i_full  = (h2i_cnt == CW'(D));
    assign h2i_empty = (h2i_cnt == '0);
    assign h2i_flush = !bus.user_w_open[c];
    assign h2i_wr    = bus.user_w_wren[c] && !h2i_full;
    assign h2i_rd    = (!vld_q || bus.in_r_read[c]) && !h2i_empty;

    always_ff @(posedge bus_clk) begin
      if (h2i_wr) h2i_mem[h2i_wp] <= bus.user_w_data[c*DATA_W +: DATA_W];
    end

    always_ff @(posedge bus_clk) begin
      if (rst || h2i_flush) begin
        h2i_wp  <= '0;
        h2i_rp  <= '0;
        h2i_cnt <= '0;
      end else begin
        if (h2i_wr) h2i_wp <= h2i_wp + 1'b1;
        if (h2i_rd) h2i_rp <= h2i_rp + 1'b1;
        h2i_cnt <= h2i_cnt + CW'(h2i_wr) - CW'(h2i_rd);
      end
    end

    always_ff @(posedge bus_clk) begin
      if (rst) begin
        dout_q <= '0;
        vld_q  <= 1'b0;
      end else if (h2i_flush) begin
        vld_q  <= 1'b0;
      end else if (h2i_rd) begin
        dout_q <= h2i_mem[h2i_rp];
        vld_q  <= 1'b1;
      end else if (bus.in_r_read[c]) begin
        vld_q  <= 1'b0;
      end
    end

    assign bus.user_w_full[c]                 = h2i_full;
    assign bus.in_r_dout[c*DATA_W +: DATA_W]  = dout_q;
    assign bus.in_r_empty_n[c]                = vld_q;

    // IP-to-host FIFO; flushed only once both host files are closed
    logic [DATA_W-1:0]     i2h_mem [D];
    logic [DEPTH_LOG2-1:0] i2h_wp, i2h_rp;
    logic [CW-1:0]         i2h_cnt, i2h_cnt_d;
    logic                  i2h_full, i2h_empty, i2h_wr, i2h_rd, i2h_flush;
    logic [DATA_W-1:0]     rdata_q;

    assign i2h_full  = (i2h_cnt == CW'(D));
    assign i2h_empty = (i2h_cnt == '0);
    assign i2h_flush = !bus.user_w_open[c] && !bus.user_r_open[c];
    assign i2h_wr    = bus.out_r_write[c] && !i2h_full;
    assign i2h_rd    = bus.user_r_rden[c] && !i2h_empty;
    assign i2h_cnt_d = i2h_flush ? '0 : (i2h_cnt + CW'(i2h_wr) - CW'(i2h_rd));

    always_ff @(posedge bus_clk) begin
      if (i2h_wr) i2h_mem[i2h_wp] <= bus.out_r_din[c*DATA_W +: DATA_W];
    end

    always_ff @(posedge bus_clk) begin
      if (rst || i2h_flush) begin
        i2h_wp <= '0;
        i2h_rp <= '0;
      end else begin
        if (i2h_wr) i2h_wp <= i2h_wp + 1'b1;
        if (i2h_rd) i2h_rp <= i2h_rp + 1'b1;
      end
    end

    always_ff @(posedge bus_clk) begin
      if (rst) begin
        i2h_cnt <= '0;
        rdata_q <= '0;
      end else begin
        i2h_cnt <= i2h_cnt_d;
        if (i2h_rd) rdata_q <= i2h_mem[i2h_rp];
      end
    end

    assign bus.out_r_full[c]                    = i2h_full;
    assign bus.user_r_empty[c]                  = i2h_empty;
    assign bus.user_r_data[c*DATA_W +: DATA_W]  = rdata_q;

`ifdef XILLY_APFIFO_EOF_EN
    // EOF once the host has opened and then closed its write file and I2H has drained
    logic seen_open_q, seen_open_d, eof_q;

    assign seen_open_d = i2h_flush ? 1'b0 : (seen_open_q || bus.user_w_open[c]);

    always_ff @(posedge bus_clk) begin
      if (rst) begin
        seen_open_q <= 1'b0;
        eof_q       <= 1'b0;
      end else begin
        seen_open_q <= seen_open_d;
        eof_q       <= seen_open_d && !bus.user_w_open[c] && (i2h_cnt_d == '0);
      end
    end

    assign bus.user_r_eof[c] = eof_q;
`else
    assign bus.user_r_eof[c] = 1'b0;
`endif
  end

  // IP held in reset while the bridge resets or every host file is closed
  always_ff @(posedge bus_clk) begin
    if (rst) ip_rst_n_q <= 1'b0;
    else     ip_rst_n_q <= |(bus.user_w_open | bus.user_r_open);
  end

  assign bus.ip_rst_n = ip_rst_n_q;
endmodule
